// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start, DATA_WIDTH data bits (LSB first),
// optional parity, one or two stop bits; frame settings latched on accept.
module uart_tx_cfg #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      Data_Valid,
  input  logic                      parity_enable,
  input  logic                      parity_type,
  input  logic                      stop_bits,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      TX_OUT,
  output logic                      busy,
  output logic                      tx_done
);

  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]                state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
  logic [PRESCALE_WIDTH-1:0] ps_last_q, ps_last_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [DATA_WIDTH-1:0]     shift_q, shift_d;
  logic                      par_bit_q, par_bit_d;
  logic                      par_en_q, par_en_d;
  logic                      stop2_q, stop2_d;
  logic                      stop_cnt_q, stop_cnt_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      bit_end;

  // Last count of a bit period is stored rather than the prescale itself,
  // which folds the prescale==0 case into a 1-cycle bit.
  assign bit_end = (cnt_q == ps_last_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ps_last_d  = ps_last_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    par_en_d   = par_en_q;
    stop2_d    = stop2_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (Data_Valid) begin
          state_d    = START;
          shift_d    = P_DATA;
          par_bit_d  = (^P_DATA) ^ parity_type;
          par_en_d   = parity_enable;
          stop2_d    = stop_bits;
          ps_last_d  = (prescale == '0) ? '0 : prescale - 1'b1;
          cnt_d      = '0;
          idx_d      = '0;
          stop_cnt_d = 1'b0;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == LAST_IDX) begin
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d    = STOP;
              tx_d       = 1'b1;
              stop_cnt_d = 1'b0;
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d    = STOP;
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ps_last_q  <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ps_last_q  <= ps_last_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      par_en_q   <= par_en_d;
      stop2_q    <= stop2_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign TX_OUT  = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the data bits per frame; legal range 5..9.
REQ-002 The block SHALL have parameter PRESCALE_WIDTH, default 16, giving the width of the prescale input.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset: CLK  input  1  clock, rising edge; RST  input  1  asynchronous active-high reset.
REQ-004 The block SHALL have port P_DATA  input  DATA_WIDTH  parallel word to transmit.
REQ-005 The block SHALL have port Data_Valid  input  1  request to send P_DATA.
REQ-006 The block SHALL have port parity_enable  input  1  1 = append parity bit.
REQ-007 The block SHALL have port parity_type  input  1  0 = even, 1 = odd.
REQ-008 The block SHALL have port stop_bits  input  1  0 = one stop bit, 1 = two stop bits.
REQ-009 The block SHALL have port prescale  input  PRESCALE_WIDTH  CLK cycles per serial bit.
REQ-010 The block SHALL have port TX_OUT  output  1  serial line, registered.
REQ-011 The block SHALL have port busy  output  1  frame in progress, registered.
REQ-012 The block SHALL have port tx_done  output  1  one-cycle pulse at frame end, registered.

Function
REQ-013 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP; transitions are IDLE->START->DATA->(PARITY if parity enabled)->STOP->IDLE.
REQ-014 In IDLE, at a rising edge with Data_Valid=1, the block SHALL capture P_DATA, parity_enable, parity_type, stop_bits and prescale into internal registers, and SHALL enter START.
REQ-015 Inputs other than RST SHALL have no effect while busy=1; Data_Valid asserted while busy=1 SHALL be ignored and not queued.
REQ-016 busy SHALL be 1 from the accepting edge until the edge that returns the FSM to IDLE.
REQ-017 TX_OUT SHALL be 0 from the accepting edge, so there is zero cycles latency from accept to the start bit.
REQ-018 Every bit (start, data, parity, stop) SHALL be held on TX_OUT for exactly the captured prescale cycles; a captured prescale of 0 SHALL be treated as 1.
REQ-019 Data bits SHALL be sent LSB first: bit k is on TX_OUT during bit slot k+1.
REQ-020 The parity bit SHALL be XOR of the captured data when parity_type=0, and the inverse of that XOR when parity_type=1.
REQ-021 The STOP state SHALL drive 1 for 1 or 2 bit periods, per the captured stop_bits.
REQ-022 Frame length SHALL be exactly prescale*(1+DATA_WIDTH+P+S) cycles, where P=parity_enable and S=1+stop_bits.
REQ-023 At the edge ending the final stop bit, the FSM SHALL enter IDLE, busy SHALL go to 0, and tx_done SHALL be 1 for exactly that one cycle.
REQ-024 If Data_Valid=1 in the first IDLE cycle after a frame, the block SHALL accept it, giving a minimum inter-frame idle of 1 cycle with TX_OUT=1.
REQ-025 TX_OUT SHALL be 1 whenever the FSM is in IDLE.
REQ-026 The bit-period counter SHALL be PRESCALE_WIDTH bits wide and SHALL count 0..prescale-1 without overflow for any prescale up to 2^PRESCALE_WIDTH-1.
REQ-027 The data-bit index counter SHALL wrap only at DATA_WIDTH-1, never at a power of two.

Reset
REQ-028 While RST=1, asynchronously and regardless of CLK, the block SHALL set TX_OUT=1, busy=0, tx_done=0, state=IDLE, and all counters and captured registers to 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately with no tx_done pulse.
REQ-030 After RST deasserts, the first Data_Valid SHALL be accepted on the first rising edge at which it is seen.

Verification
REQ-031 The bench SHALL cover basic 8N1: prescale=4, P_DATA=0xA5, parity off, 1 stop -> TX_OUT 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; busy high for 40 cycles; tx_done pulses once.
REQ-032 The bench SHALL cover parity even and odd: prescale=2, P_DATA=0x07 -> parity bit 1 (even) and 0 (odd); frame 22 cycles.
REQ-033 The bench SHALL cover two stop bits with DATA_WIDTH=7: prescale=3, P_DATA=0x7F, stop_bits=1 -> stop high for 6 cycles; total 30 cycles.
REQ-034 The bench SHALL cover ignored request and config change: Data_Valid pulsed mid-frame with P_DATA=0x00 and prescale changed -> the current frame is unchanged and no second frame is sent.
REQ-035 The bench SHALL cover back-to-back frames and prescale=0: Data_Valid held high, prescale=0 -> every bit lasts 1 cycle, frames are separated by exactly 1 idle cycle, and tx_done pulses once per frame.
REQ-036 The bench SHALL cover reset mid-frame: RST asserted during data bit 3 -> TX_OUT=1 and busy=0 immediately, before the next CLK edge, and no tx_done pulse.
